// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: load/store op codes, FSM states,
// byte-select patterns and small lane-select helpers.
package mem_stage_pkg;

  // Load/store op codes as produced by the EX stage
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [4:0] NOP_REG_ADDR = 5'b00000;
  localparam logic       NO_STOP      = 1'b0;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } mem_state_e;

  // Big-endian: offset 0 is the most significant byte lane
  function automatic logic [3:0] byte_sel(input logic [1:0] off);
    return 4'b1000 >> off;
  endfunction

  function automatic logic [3:0] half_sel(input logic off_hi);
    return off_hi ? 4'b0011 : 4'b1100;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-bus interface between the MEM stage (master) and memory (slave).
//   req/we/addr/sel/wdata : master -> slave, held until ack
//   rdata/ack             : slave -> master, ack is a one-cycle completion
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, sel, wdata, input rdata, ack);
  modport slave  (input req, we, addr, sel, wdata, output rdata, ack);
endinterface

// File: rtl/mem_align.sv
// Combinational byte-lane unit for the MEM stage.
//   aluop_i/off_i : op code and low address bits
//   reg2_i        : store data, replicated across lanes on wdata_o
//   rdata_i       : captured read word, lane extracted and extended on ldata_o
//   is_load_o/is_store_o/misalign_o/sel_o : access decode
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [7:0]  aluop_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] rdata_i,
  output logic        is_load_o,
  output logic        is_store_o,
  output logic        misalign_o,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword out of the read word
  always_comb begin
    case (off_i)
      2'b00:   byte_s = rdata_i[31:24];
      2'b01:   byte_s = rdata_i[23:16];
      2'b10:   byte_s = rdata_i[15:8];
      default: byte_s = rdata_i[7:0];
    endcase
    if (off_i[1]) begin
      half_s = rdata_i[15:0];
    end else begin
      half_s = rdata_i[31:16];
    end
  end

  // Decode the access: lanes, store replication, load extension
  always_comb begin
    is_load_o  = 1'b0;
    is_store_o = 1'b0;
    misalign_o = 1'b0;
    sel_o      = SEL_NONE;
    wdata_o    = 32'h0000_0000;
    ldata_o    = 32'h0000_0000;
    case (aluop_i)
      EXE_LB_OP: begin
        is_load_o = 1'b1;
        sel_o     = byte_sel(off_i);
        ldata_o   = {{24{byte_s[7]}}, byte_s};
      end
      EXE_LBU_OP: begin
        is_load_o = 1'b1;
        sel_o     = byte_sel(off_i);
        ldata_o   = {24'h00_0000, byte_s};
      end
      EXE_LH_OP: begin
        is_load_o  = 1'b1;
        misalign_o = off_i[0];
        sel_o      = half_sel(off_i[1]);
        ldata_o    = {{16{half_s[15]}}, half_s};
      end
      EXE_LHU_OP: begin
        is_load_o  = 1'b1;
        misalign_o = off_i[0];
        sel_o      = half_sel(off_i[1]);
        ldata_o    = {16'h0000, half_s};
      end
      EXE_LW_OP: begin
        is_load_o  = 1'b1;
        misalign_o = |off_i;
        sel_o      = SEL_WORD;
        ldata_o    = rdata_i;
      end
      EXE_SB_OP: begin
        is_store_o = 1'b1;
        sel_o      = byte_sel(off_i);
        wdata_o    = {4{reg2_i[7:0]}};
      end
      EXE_SH_OP: begin
        is_store_o = 1'b1;
        misalign_o = off_i[0];
        sel_o      = half_sel(off_i[1]);
        wdata_o    = {2{reg2_i[15:0]}};
      end
      EXE_SW_OP: begin
        is_store_o = 1'b1;
        misalign_o = |off_i;
        sel_o      = SEL_WORD;
        wdata_o    = reg2_i;
      end
      default: begin
        is_load_o  = 1'b0;
        is_store_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline. Runs loads/stores over a req/ack
// data bus and stalls the pipeline until each access completes; all other
// ops pass straight through to the MEM/WB register.
//   clk, rst           : clock, synchronous active-high reset
//   stall              : ctrl stall vector, bit 4 holds MEM/WB
//   *_i                : EX/MEM register contents
//   dbus               : data-bus master port
//   mem_*              : MEM/WB inputs
//   stallreq_mem       : stall request to ctrl
//   addr_err, bus_err  : misaligned access (comb), timeout abort (pulse)
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16  // 2..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        whilo_i,
  mem_stage_if.master dbus,
  output logic [31:0] mem_wdata,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic        stallreq_mem,
  output logic        addr_err,
  output logic        bus_err
);

  // The counter already reads 1 in the first WAIT cycle, so abort at
  // TIMEOUT-1 gives exactly TIMEOUT request cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  mem_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        abort_q, abort_d;
  logic        bus_err_q, bus_err_d;

  logic        is_load_s, is_store_s, misalign_s, mem_op_s, req_s;
  logic [3:0]  sel_s;
  logic [31:0] st_data_s, ld_data_s;
  logic        stall_unused_s;

  assign stall_unused_s = ^{stall[5], stall[3:0]};
  assign mem_op_s       = is_load_s | is_store_s;

  mem_align u_align (
    .aluop_i    (aluop_i),
    .off_i      (mem_addr_i[1:0]),
    .reg2_i     (reg2_i),
    .rdata_i    (rdata_q),
    .is_load_o  (is_load_s),
    .is_store_o (is_store_s),
    .misalign_o (misalign_s),
    .sel_o      (sel_s),
    .wdata_o    (st_data_s),
    .ldata_o    (ld_data_s)
  );

  // State, timeout counter, captured read data and abort flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      rdata_q   <= 32'h0000_0000;
      abort_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      abort_q   <= abort_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state logic; ack takes priority over timeout in WAIT
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    abort_d   = abort_q;
    bus_err_d = 1'b0;
    req_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op_s && !misalign_s) begin
          req_s   = 1'b1;
          abort_d = 1'b0;
          if (dbus.ack) begin
            rdata_d = dbus.rdata;
            state_d = ST_DONE;
          end else begin
            cnt_d   = 8'd1;
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        req_s = 1'b1;
        if (dbus.ack) begin
          rdata_d = dbus.rdata;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          abort_d   = 1'b1;
          bus_err_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        if (stall[4] == NO_STOP) begin
          cnt_d   = 8'd0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output steering: bus drive, MEM/WB results, pass-through and reset blanking
  always_comb begin
    dbus.req     = 1'b0;
    dbus.we      = 1'b0;
    dbus.addr    = 32'h0000_0000;
    dbus.sel     = SEL_NONE;
    dbus.wdata   = 32'h0000_0000;
    mem_wdata    = 32'h0000_0000;
    mem_wd       = NOP_REG_ADDR;
    mem_wreg     = 1'b0;
    mem_hi       = 32'h0000_0000;
    mem_lo       = 32'h0000_0000;
    mem_whilo    = 1'b0;
    stallreq_mem = 1'b0;
    addr_err     = 1'b0;
    bus_err      = 1'b0;
    if (rst) begin
      stallreq_mem = 1'b0;
    end else begin
      mem_wd    = wd_i;
      mem_hi    = hi_i;
      mem_lo    = lo_i;
      mem_whilo = whilo_i;
      bus_err   = bus_err_q;
      if (req_s) begin
        dbus.req     = 1'b1;
        dbus.we      = is_store_s;
        dbus.addr    = {mem_addr_i[31:2], 2'b00};
        dbus.sel     = sel_s;
        dbus.wdata   = st_data_s;
        stallreq_mem = 1'b1;
      end else begin
        stallreq_mem = 1'b0;
      end
      if (!mem_op_s) begin
        mem_wdata = wdata_i;
        mem_wreg  = wreg_i;
      end else if (state_q == ST_DONE) begin
        mem_wdata = is_load_s ? ld_data_s : wdata_i;
        mem_wreg  = wreg_i & is_load_s & ~abort_q;
      end else if (misalign_s) begin
        addr_err  = 1'b1;
        mem_wdata = wdata_i;
        mem_wreg  = 1'b0;
      end else begin
        mem_wdata = 32'h0000_0000;
        mem_wreg  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// loads/stores/ALU ops, checked against an arithmetic reference model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 16;
  localparam logic [7:0] OR_OP = 8'h25;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, hi_i, lo_i;
  logic [4:0]  wd_i;
  logic        wreg_i, whilo_i;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_whilo, stallreq_mem, addr_err, bus_err;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .stall(stall), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
    .dbus(bus),
    .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .stallreq_mem(stallreq_mem), .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, want);
    end
  endtask

  // Reference model helpers
  function automatic int op_size(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 1;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2;
      EXE_LW_OP, EXE_SW_OP:             return 4;
      default:                          return 0;
    endcase
  endfunction

  function automatic bit op_load(input logic [7:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic bit op_signed(input logic [7:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LH_OP);
  endfunction

  // One load/store; lat = WAIT cycles before ack (>= TO means never acked)
  task automatic do_access(input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] d2, input logic [31:0] rd, input int lat);
    int n, off, shift, req_cnt, e_req;
    bit ld, abort, done;
    logic [31:0] e_sel, e_wd, e_ld, mask;
    n  = op_size(op);
    off = int'(addr[1:0]);
    ld = op_load(op);
    @(posedge clk); #1;
    aluop_i = op; mem_addr_i = addr; reg2_i = d2; rst = 1'b0;
    wd_i = 5'($urandom); wreg_i = 1'b1; wdata_i = $urandom; stall = 6'd0;
    bus.ack = 1'b0; bus.rdata = rd;
    if ((off % n) != 0) begin
      @(negedge clk);
      check("mis_addr_err", 32'(addr_err), 32'd1);
      check("mis_req", 32'(bus.req), 32'd0);
      check("mis_stall", 32'(stallreq_mem), 32'd0);
      check("mis_wreg", 32'(mem_wreg), 32'd0);
      return;
    end
    e_sel = 32'(((1 << n) - 1) << (4 - off - n));
    case (n)
      1:       e_wd = {24'h0, d2[7:0]} * 32'h0101_0101;
      2:       e_wd = {16'h0, d2[15:0]} * 32'h0001_0001;
      default: e_wd = d2;
    endcase
    shift = 8 * (4 - off - n);
    mask  = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
    e_ld  = (rd >> shift) & mask;
    if (op_signed(op) && e_ld[8*n-1]) e_ld = e_ld | ~mask;
    abort = (lat > TO - 1);
    e_req = abort ? TO : lat + 1;
    req_cnt = 0;
    done = 1'b0;
    for (int c = 0; c < TO + 8; c++) begin
      bus.ack = (c == lat);
      @(negedge clk);
      if (!bus.req) begin
        done = 1'b1;
        break;
      end
      req_cnt++;
      check("stallreq", 32'(stallreq_mem), 32'd1);
      check("sel", 32'(bus.sel), e_sel);
      check("addr", bus.addr, addr & ~32'h3);
      check("we", 32'(bus.we), 32'(!ld));
      if (!ld) check("st_wdata", bus.wdata, e_wd);
      @(posedge clk); #1;
    end
    bus.ack = 1'b0;
    check("done_reached", 32'(done), 32'd1);
    check("req_cycles", 32'(req_cnt), 32'(e_req));
    check("done_stall", 32'(stallreq_mem), 32'd0);
    check("bus_err", 32'(bus_err), 32'(abort));
    check("mem_wd", 32'(mem_wd), 32'(wd_i));
    if (ld && !abort) begin
      check("ld_data", mem_wdata, e_ld);
      check("ld_wreg", 32'(mem_wreg), 32'd1);
    end else begin
      check("no_wreg", 32'(mem_wreg), 32'd0);
    end
  endtask

  // Non-memory op: everything passes straight through
  task automatic pass_op();
    @(posedge clk); #1;
    aluop_i = OR_OP; mem_addr_i = $urandom; wd_i = 5'($urandom); wreg_i = 1'($urandom);
    wdata_i = $urandom; hi_i = $urandom; lo_i = $urandom; whilo_i = 1'($urandom);
    stall = 6'd0; bus.ack = 1'b0;
    @(negedge clk);
    check("pass_wdata", mem_wdata, wdata_i);
    check("pass_wd", 32'(mem_wd), 32'(wd_i));
    check("pass_wreg", 32'(mem_wreg), 32'(wreg_i));
    check("pass_hi", mem_hi, hi_i);
    check("pass_lo", mem_lo, lo_i);
    check("pass_whilo", 32'(mem_whilo), 32'(whilo_i));
    check("pass_req", 32'(bus.req), 32'd0);
    check("pass_addr_err", 32'(addr_err), 32'd0);
  endtask

  logic [7:0] ops [8] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
                          EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};

  initial begin
    rst = 1'b1; stall = 6'd0; aluop_i = EXE_LW_OP; mem_addr_i = 32'h0000_0101;
    reg2_i = 32'h1234_5678; wd_i = 5'h1F; wreg_i = 1'b1; wdata_i = 32'hCAFE_F00D;
    hi_i = 32'h1111_1111; lo_i = 32'h2222_2222; whilo_i = 1'b1;
    bus.ack = 1'b0; bus.rdata = 32'h0;

    // Reset: all outputs blanked, mem_wd = NOP register
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_wd", 32'(mem_wd), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_hi", mem_hi, 32'd0);
    check("rst_whilo", 32'(mem_whilo), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);

    // Directed cases
    do_access(EXE_LW_OP, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3);
    do_access(EXE_LB_OP, 32'h0000_0103, 32'h0, 32'h1122_33F4, 0);
    do_access(EXE_LBU_OP, 32'h0000_0103, 32'h0, 32'h1122_33F4, 0);
    do_access(EXE_SH_OP, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 1);
    do_access(EXE_LW_OP, 32'h0000_0101, 32'h0, 32'h0, 0);
    do_access(EXE_LH_OP, 32'h0000_0102, 32'h0, 32'h0000_8001, 15);  // ack on the last legal cycle
    do_access(EXE_LW_OP, 32'h0000_0200, 32'h0, 32'h5555_AAAA, 1000);

    // Hold DONE after the abort: bus_err must already be gone
    stall = 6'b01_0000;
    @(negedge clk);
    check("hold_bus_err", 32'(bus_err), 32'd0);
    check("hold_req", 32'(bus.req), 32'd0);
    check("hold_wreg", 32'(mem_wreg), 32'd0);
    stall = 6'd0;
    @(posedge clk); #1;
    aluop_i = OR_OP;
    do_access(EXE_LW_OP, 32'h0000_0204, 32'h0, 32'h0BAD_F00D, 2);

    // Reset in the second WAIT cycle, then a stray ack
    @(posedge clk); #1;
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h0000_0300; bus.ack = 1'b0; bus.rdata = 32'hFEED_FACE;
    @(negedge clk);
    check("pre_rst_req", 32'(bus.req), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("wrst_req", 32'(bus.req), 32'd0);
    check("wrst_stall", 32'(stallreq_mem), 32'd0);
    check("wrst_wdata", mem_wdata, 32'd0);
    check("wrst_wd", 32'(mem_wd), 32'd0);
    check("wrst_lo", mem_lo, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; aluop_i = OR_OP; bus.ack = 1'b1;
    @(negedge clk);
    check("late_ack_req", 32'(bus.req), 32'd0);
    check("late_ack_wdata", mem_wdata, wdata_i);
    @(posedge clk); #1;
    bus.ack = 1'b0;
    do_access(EXE_LHU_OP, 32'h0000_0302, 32'h0, 32'h1234_9876, 2);

    // Random mix
    for (int i = 0; i < 60; i++) begin
      int pick;
      int lat;
      pick = $urandom_range(0, 8);
      if (pick == 8) begin
        pass_op();
      end else begin
        lat = $urandom_range(0, 9);
        lat = (lat == 9) ? 1000 : lat % 4;
        do_access(ops[pick], $urandom, $urandom, $urandom, lat);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
